// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU.
// One quotient bit per cycle; remainder to HI, quotient to LO.
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] prem_q, prem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0] dvs_abs;
   // One extra bit keeps the shifted remainder exact for large unsigned divisors
   logic [WIDTH:0]   rem_tmp;
   logic [WIDTH:0]   diff;

   // State and datapath registers; reset clears everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prem_q  <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prem_q  <= prem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state logic: operand capture, shift/subtract step, sign fix-up
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prem_d  = prem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      dvs_abs = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
      rem_tmp = {prem_q, quo_q[WIDTH-1]};
      diff    = rem_tmp - {1'b0, dvs_q};

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  dz_d    = 1'b1;
                  quo_d   = dividend;
                  state_d = S_FIX;
               end else begin
                  dz_d    = 1'b0;
                  quo_d   = dvd_abs;
                  dvs_d   = dvs_abs;
                  prem_d  = '0;
                  cnt_d   = CW'(WIDTH);
                  qneg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  rneg_d  = is_signed & dividend[WIDTH-1];
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (!diff[WIDTH]) begin
               prem_d = diff[WIDTH-1:0];
               quo_d  = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               prem_d = rem_tmp[WIDTH-1:0];
               quo_d  = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (dz_q) begin
               quot_d = '1;
               rem_d  = quo_q;
               dbz_d  = 1'b1;
            end else begin
               quot_d = qneg_q ? -quo_q : quo_q;
               rem_d  = rneg_q ? -prem_q : prem_q;
               dbz_d  = 1'b0;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule
